// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-requestor arbiter in front of the single memory port.
// One transaction in flight: IDLE (grant) -> BUSY (memory request) -> RESP (pulse).
module mem_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 16,
  parameter int DATA_BYTES = 3,
  parameter int PRIO_MODE  = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_PORTS-1:0]      req_valid_i,
  output logic [NUM_PORTS-1:0]      req_ready_o,
  input  logic [NUM_PORTS-1:0]      req_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*8-1:0]    req_wdata_i,
  output logic [NUM_PORTS-1:0]      rsp_valid_o,
  output logic                      rsp_err_o,
  output logic [DATA_BYTES*8-1:0]   rsp_rdata_o,
  output logic                      busy_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [7:0]                mem_wdata_o,
  input  logic [DATA_BYTES*8-1:0]   mem_rdata_i,
  input  logic                      mem_ack_i
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RD_W  = DATA_BYTES * 8;
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [RD_W-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [PTR_W-1:0]   scan_idx;

  // Grant search: from port 0 upward (fixed) or from pointer+1 with wrap (round-robin)
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = (PRIO_MODE == 1) ? PTR_W'((int'(ptr_q) + 1 + i) % NUM_PORTS) : PTR_W'(i);
      if (!gnt_any && req_valid_i[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Next-state, request latch, watchdog and response capture
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = BUSY;
          gnt_d   = gnt_idx;
          we_d    = req_we_i[gnt_idx];
          addr_d  = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[gnt_idx*8 +: 8];
          cnt_d   = '0;
          if (PRIO_MODE == 1) ptr_d = gnt_idx;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // ack has precedence over a watchdog expiry in the same cycle
        if (mem_ack_i) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : mem_rdata_i;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state so the memory request drops as soon as reset asserts
  always_comb begin
    req_ready_o = (rstn_i && state_q == IDLE && gnt_any) ? (NUM_PORTS'(1) << gnt_idx) : '0;
    rsp_valid_o = (state_q == RESP) ? (NUM_PORTS'(1) << gnt_q) : '0;
    rsp_err_o   = (state_q == RESP) && err_q;
    rsp_rdata_o = rdata_q;
    busy_o      = (state_q != IDLE);
    mem_req_o   = (state_q == BUSY);
    mem_we_o    = (state_q == BUSY) && we_q;
    mem_addr_o  = (state_q == BUSY) ? addr_q : '0;
    mem_wdata_o = (state_q == BUSY) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks on a fixed-priority and a round-robin instance.
module tb_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 16;
  localparam int DB = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // instance a: fixed priority
  logic [NP-1:0]    a_valid, a_we, a_ready, a_rsp;
  logic [NP*AW-1:0] a_addr;
  logic [NP*8-1:0]  a_wdata;
  logic             a_err, a_busy, a_mreq, a_mwe, a_ack;
  logic [AW-1:0]    a_maddr;
  logic [7:0]       a_mwdata;
  logic [DB*8-1:0]  a_rdata, a_mrdata;
  // instance b: round-robin
  logic [NP-1:0]    b_valid, b_we, b_ready, b_rsp;
  logic [NP*AW-1:0] b_addr;
  logic [NP*8-1:0]  b_wdata;
  logic             b_err, b_busy, b_mreq, b_mwe, b_ack;
  logic [AW-1:0]    b_maddr;
  logic [7:0]       b_mwdata;
  logic [DB*8-1:0]  b_rdata, b_mrdata;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_BYTES(DB), .PRIO_MODE(0), .TIMEOUT(TO)) u_a (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .rsp_valid_o(a_rsp), .rsp_err_o(a_err),
    .rsp_rdata_o(a_rdata), .busy_o(a_busy), .mem_req_o(a_mreq), .mem_we_o(a_mwe),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mrdata), .mem_ack_i(a_ack));

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_BYTES(DB), .PRIO_MODE(1), .TIMEOUT(TO)) u_b (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .rsp_valid_o(b_rsp), .rsp_err_o(b_err),
    .rsp_rdata_o(b_rdata), .busy_o(b_busy), .mem_req_o(b_mreq), .mem_we_o(b_mwe),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata), .mem_ack_i(b_ack));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  seen;
    a_valid = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_mrdata = '0; a_ack = 1'b1;
    b_valid = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_mrdata = '0; b_ack = 1'b0;

    // reset state, ready forced low while in reset
    a_valid = 3'b001;
    #12;
    chk("rst_ready", 32'(a_ready), 32'h0);
    chk("rst_mreq",  32'(a_mreq),  32'h0);
    chk("rst_rsp",   32'(a_rsp),   32'h0);
    chk("rst_rdata", 32'(a_rdata), 32'h0);
    chk("rst_busy",  32'(a_busy),  32'h0);
    a_valid = '0;
    rstn = 1'b1;

    // stray ack right after reset is ignored
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("stray_busy%0d", c), 32'(a_busy), 32'h0);
      chk($sformatf("stray_rsp%0d", c),  32'(a_rsp),  32'h0);
    end
    a_ack = 1'b0;

    // single read: port 0 @C000, ack after 2 BUSY cycles
    a_valid = 3'b001; a_addr[15:0] = 16'hC000;
    #1;
    chk("rd_ready", 32'(a_ready), 32'h1);
    tick();
    a_valid = '0;
    #1;
    chk("rd_mreq1", 32'(a_mreq), 32'h1);
    chk("rd_addr1", 32'(a_maddr), 32'hC000);
    chk("rd_we1",   32'(a_mwe), 32'h0);
    tick();
    a_ack = 1'b1; a_mrdata = 24'hA91234;
    #1;
    chk("rd_mreq2", 32'(a_mreq), 32'h1);
    chk("rd_addr2", 32'(a_maddr), 32'hC000);
    tick();
    a_ack = 1'b0;
    #1;
    chk("rd_rsp",   32'(a_rsp), 32'h1);
    chk("rd_err",   32'(a_err), 32'h0);
    chk("rd_rdata", 32'(a_rdata), 32'hA91234);
    chk("rd_mreq3", 32'(a_mreq), 32'h0);
    tick();
    chk("rd_rsp_off", 32'(a_rsp), 32'h0);
    chk("rd_hold",    32'(a_rdata), 32'hA91234);
    chk("rd_idle",    32'(a_busy), 32'h0);

    // write: port 2 writes 5A to 0200, ack on first BUSY cycle
    a_valid = 3'b100; a_we = 3'b100; a_addr[47:32] = 16'h0200; a_wdata[23:16] = 8'h5A;
    #1;
    chk("wr_ready", 32'(a_ready), 32'h4);
    tick();
    a_valid = '0; a_we = '0;
    a_ack = 1'b1; a_mrdata = 24'hFFFFFF;
    #1;
    chk("wr_we",    32'(a_mwe), 32'h1);
    chk("wr_wdata", 32'(a_mwdata), 32'h5A);
    chk("wr_addr",  32'(a_maddr), 32'h0200);
    tick();
    a_ack = 1'b0;
    #1;
    chk("wr_rsp",   32'(a_rsp), 32'h4);
    chk("wr_rdata", 32'(a_rdata), 32'h0);
    tick();

    // fixed priority: ports 0 and 1 held valid, port 0 always wins
    a_valid = 3'b011; a_ack = 1'b1; a_mrdata = 24'h777777;
    a_addr[15:0] = 16'h1000; a_addr[31:16] = 16'h2000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fp_ready%0d", k), 32'(a_ready), 32'h1);
      tick();
      chk($sformatf("fp_addr%0d", k), 32'(a_maddr), 32'h1000);
      chk($sformatf("fp_nrdy_b%0d", k), 32'(a_ready), 32'h0);
      tick();
      chk($sformatf("fp_rsp%0d", k), 32'(a_rsp), 32'h1);
      chk($sformatf("fp_nrdy_r%0d", k), 32'(a_ready), 32'h0);
      tick();
    end
    a_valid = '0; a_ack = 1'b0;

    // round-robin: all ports valid, grants rotate 0,1,2,0,1,2 every 3 cycles
    b_valid = 3'b111; b_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), 32'(b_ready), 32'(1 << (k % 3)));
      tick();
      chk($sformatf("rr_busy%0d", k), 32'(b_busy), 32'h1);
      tick();
      chk($sformatf("rr_rsp%0d", k), 32'(b_rsp), 32'(1 << (k % 3)));
      tick();
    end
    b_valid = '0; b_ack = 1'b0;

    // timeout: port 1 read, no ack
    a_valid = 3'b010; a_addr[31:16] = 16'h3333;
    #1;
    chk("to_ready", 32'(a_ready), 32'h2);
    tick();
    a_valid = '0;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      #1;
      if (a_rsp != 0) seen = 1'b1;
      else begin
        if (a_mreq) n++;
        tick();
      end
    end
    chk("to_seen",  32'(seen), 32'h1);
    chk("to_cycles", 32'(n), 32'h4);
    chk("to_rsp",   32'(a_rsp), 32'h2);
    chk("to_err",   32'(a_err), 32'h1);
    chk("to_rdata", 32'(a_rdata), 32'h0);
    tick();

    // ack in the 4th BUSY cycle wins over the watchdog
    a_valid = 3'b010;
    tick();
    a_valid = '0;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      #1;
      if (a_rsp != 0) begin
        seen = 1'b1;
        a_ack = 1'b0;
      end else begin
        if (a_mreq) begin
          n++;
          if (n == 4) begin a_ack = 1'b1; a_mrdata = 24'h123456; end
        end
        tick();
      end
    end
    a_ack = 1'b0;
    chk("ta_seen",  32'(seen), 32'h1);
    chk("ta_cycles", 32'(n), 32'h4);
    chk("ta_err",   32'(a_err), 32'h0);
    chk("ta_rdata", 32'(a_rdata), 32'h123456);
    tick();

    // reset mid-BUSY on both instances; b's pointer moves to 0 first
    a_valid = 3'b001; b_valid = 3'b001;
    tick();
    a_valid = '0; b_valid = '0;
    #1;
    chk("rb_mreq_pre", 32'(a_mreq), 32'h1);
    rstn = 1'b0;
    #1;
    chk("rb_mreq", 32'(a_mreq), 32'h0);
    chk("rb_busy_a", 32'(a_busy), 32'h0);
    chk("rb_busy_b", 32'(b_busy), 32'h0);
    a_valid = 3'b001;
    #1;
    chk("rb_ready", 32'(a_ready), 32'h0);
    a_valid = '0;
    #1;
    rstn = 1'b1;
    a_ack = 1'b1; b_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rb_rsp%0d", c),  32'(a_rsp | b_rsp), 32'h0);
      chk($sformatf("rb_idle%0d", c), 32'(a_busy | b_busy | a_mreq), 32'h0);
    end
    a_ack = 1'b0; b_ack = 1'b0;
    b_valid = 3'b111;
    #1;
    chk("rb_ptr", 32'(b_ready), 32'h1);
    b_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // overall watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised multi-requestor memory arbiter sitting between the CPU pipeline (fetch, operand fetch, data store) and the single memory port. It replaces the hard-wired always-valid memory assumption with a real valid/ready request handshake, a memory ack, a timeout watchdog and per-port responses. Its per-port response pulse drives the CPU control's mem_valid_i.

Parameters:
NUM_PORTS, 3, number of requestors (>=1); port 0 = fetch.
ADDR_W, 16, memory address width (matches MEM_ADDR_SIZE).
DATA_BYTES, 3, bytes returned per read (opcode + 2 operand bytes).
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
TIMEOUT, 15, BUSY cycles without ack before error response; 0 disables the watchdog.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  asynchronous active-low reset.
req_valid_i  in  NUM_PORTS  per-port request valid.
req_ready_o  out  NUM_PORTS  per-port accept; one-hot or zero.
req_we_i  in  NUM_PORTS  per-port write enable.
req_addr_i  in  NUM_PORTS*ADDR_W  packed addresses; port p at [p*ADDR_W +: ADDR_W].
req_wdata_i  in  NUM_PORTS*8  packed write bytes.
rsp_valid_o  out  NUM_PORTS  one-cycle one-hot completion pulse.
rsp_err_o  out  1  qualifies rsp_valid_o: timeout occurred.
rsp_rdata_o  out  DATA_BYTES*8  read data; shared by all ports.
busy_o  out  1  state != IDLE.
mem_req_o  out  1  memory request.
mem_we_o  out  1  memory write.
mem_addr_o  out  ADDR_W  memory address.
mem_wdata_o  out  8  memory write byte.
mem_rdata_i  in  DATA_BYTES*8  memory read data; valid with mem_ack_i.
mem_ack_i  in  1  memory completion.

Behaviour:
- Clock is clk_i. Reset is asynchronous and active-low on rstn_i. Reset clears the FSM to IDLE, the round-robin pointer to NUM_PORTS-1, the latched request and the timeout counter. All registered outputs reset to 0, rsp_rdata_o included. req_ready_o is combinationally forced to 0 while rstn_i is low.
- FSM states: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - The grant g is computed combinationally from req_valid_i.
  - PRIO_MODE 0: lowest-index valid port.
  - PRIO_MODE 1: first valid port searched from pointer+1 upward, wrapping modulo NUM_PORTS.
  - req_ready_o[g] = 1 only in IDLE when any valid is set.
  - On valid & ready: latch g, we, addr and wdata; go to BUSY; clear the timeout counter; set the pointer to g (round-robin mode only).
  - The pointer is not updated when no request is accepted.
- BUSY:
  - mem_req_o = 1.
  - mem_we_o, mem_addr_o and mem_wdata_o come from the latched request and are held stable until ack or timeout.
  - The timeout counter increments each BUSY cycle.
  - If mem_ack_i = 1: capture mem_rdata_i into rsp_rdata_o (capture 0 for writes), set err = 0, go to RESP.
  - Else if TIMEOUT != 0 and the counter reaches TIMEOUT-1: set rsp_rdata_o = 0, set err = 1, go to RESP.
  - Ack and timeout in the same cycle: ack wins, err = 0.
- RESP:
  - rsp_valid_o[latched g] = 1 and rsp_err_o = err, for exactly one cycle.
  - mem_req_o = 0. Go to IDLE.
  - rsp_rdata_o holds its value until the next capture.
- Outside BUSY, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are 0. mem_ack_i is ignored outside BUSY, including a stray ack arriving right after reset.
- Minimum transaction time:
  - Accept at cycle 0, ack at cycle 1, rsp_valid_o at cycle 2.
  - Next accept at cycle 3, giving 1 transaction per 3 cycles.
- req_valid_i deasserting while not ready is permitted and causes no side effect. A requestor must hold its request until ready.
- Reset mid-transaction:
  - Immediate abort; mem_req_o drops asynchronously.
  - No rsp_valid_o is issued for the aborted request.
- Width rules: the counter is $clog2(TIMEOUT+1) bits (minimum 1). Pointer arithmetic wraps modulo NUM_PORTS, including non-power-of-2 values.

Test Plan:
- Single read, PRIO_MODE 0, NUM_PORTS=3: port 0 reads 16'hC000; memory acks after 2 BUSY cycles with 24'hA9_12_34 -> mem_addr_o=16'hC000 with mem_we_o=0 for 2 cycles, then rsp_valid_o=3'b001, rsp_err_o=0, rsp_rdata_o=24'hA91234.
- Write: port 2 writes 8'h5A to 16'h0200; memory acks on the first BUSY cycle -> mem_we_o=1, mem_wdata_o=8'h5A; rsp_valid_o=3'b100 two cycles after accept; rsp_rdata_o=0.
- Fixed priority: ports 0 and 1 both valid continuously for 4 transactions -> port 0 granted all 4 times; port 1 is never ready.
- Round-robin, PRIO_MODE 1: all 3 ports valid continuously -> grant order 0, 1, 2, 0, 1, 2, one grant every 3 cycles with immediate acks.
- Timeout, TIMEOUT=4: no ack -> mem_req_o high for exactly 4 cycles, then rsp_valid_o pulses with rsp_err_o=1 and rsp_rdata_o=0. Repeat with ack in the 4th cycle -> rsp_err_o=0.
- Reset mid-BUSY: assert rstn_i=0 during BUSY, then ack after release -> mem_req_o=0 immediately, no rsp_valid_o, busy_o=0, pointer back to NUM_PORTS-1.
